serial_deserializer: RTL and testbench

Bit-serial to parallel converter downstream of the serial two's-complement stage. Collects WIDTH bits arriving LSB-first on `serIn`, one per clock, starting on the cycle `start` is asserted. Presents the assembled word to a parallel consumer through a valid/ready handshake. Detects frames that start while an unaccepted word is still held.

---
 rtl/serial_deserializer_if.sv | 22 ++
 rtl/serial_deserializer.sv | 99 +++++++++
 tb/tb_serial_deserializer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_deserializer_if.sv
// rtl/serial_deserializer_if.sv - serial-in / parallel-out handshake bundle for serial_deserializer
interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             serIn;
    logic             ready;
    logic [WIDTH-1:0] dataOut;
    logic             valid;
    logic             busy;
    logic             overrun;

    modport master (
        output start, serIn, ready,
        input  dataOut, valid, busy, overrun
    );

    modport slave (
        input  start, serIn, ready,
        output dataOut, valid, busy, overrun
    );
endinterface

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - LSB-first bit-serial to parallel converter with valid/ready output
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset_L,
    serial_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovr_q, ovr_d;
    logic             valid_q, busy_q;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first;

    // New bits enter at the MSB so that bit 0 ends at the LSB after WIDTH samples.
    assign shifted = {bus.serIn, sh_q[WIDTH-1:1]};
    assign first   = {bus.serIn, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_d    = first;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.start) begin
                    sh_d  = first;
                    cnt_d = CW'(1);
                end else begin
                    sh_d  = shifted;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        data_d  = shifted;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.ready) begin
                    if (bus.start) begin
                        sh_d    = first;
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.start) begin
                    // The held word wins; the incoming frame is dropped whole.
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
            valid_q <= (state_d == HOLD);
            busy_q  <= (state_d == SHIFT);
        end
    end

    assign bus.dataOut = data_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - randomized and directed check of serial_deserializer at WIDTH 8 and 2
module tb_serial_deserializer;
    logic clock;
    logic reset_L;

    serial_deserializer_if #(.WIDTH(8)) bus8 ();
    serial_deserializer_if #(.WIDTH(2)) bus2 ();

    serial_deserializer #(.WIDTH(8)) dut8 (.clock(clock), .reset_L(reset_L), .bus(bus8.slave));
    serial_deserializer #(.WIDTH(2)) dut2 (.clock(clock), .reset_L(reset_L), .bus(bus2.slave));

    int total = 0;
    int bad   = 0;

    // Reference: a frame is a list of bits counted until WIDTH arrive; word = sum(bit_i * 2^i).
    int W    [2] = '{8, 2};
    bit inf  [2];
    int nb   [2];
    int acc  [2];
    bit held [2];
    int dout [2];
    bit ovr  [2];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            inf[k] = 0; nb[k] = 0; acc[k] = 0; held[k] = 0; dout[k] = 0; ovr[k] = 0;
        end
    endtask

    task automatic model_step(input bit s, input bit b, input bit r);
        for (int k = 0; k < 2; k++) begin
            bit ovr_n;
            ovr_n = 0;
            if (held[k]) begin
                if (r) begin
                    held[k] = 0;
                    if (s) begin inf[k] = 1; acc[k] = int'(b); nb[k] = 1; end
                end else if (s) begin
                    ovr_n = 1;
                end
            end else if (s) begin
                inf[k] = 1; acc[k] = int'(b); nb[k] = 1;
            end else if (inf[k]) begin
                acc[k] = acc[k] + (int'(b) << nb[k]);
                nb[k]  = nb[k] + 1;
                if (nb[k] == W[k]) begin
                    dout[k] = acc[k];
                    held[k] = 1;
                    inf[k]  = 0;
                end
            end
            ovr[k] = ovr_n;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("valid8",   32'(bus8.valid),   32'(held[0]));
        check("busy8",    32'(bus8.busy),    32'(inf[0]));
        check("overrun8", 32'(bus8.overrun), 32'(ovr[0]));
        check("data8",    32'(bus8.dataOut), 32'(dout[0]));
        check("valid2",   32'(bus2.valid),   32'(held[1]));
        check("busy2",    32'(bus2.busy),    32'(inf[1]));
        check("overrun2", 32'(bus2.overrun), 32'(ovr[1]));
        check("data2",    32'(bus2.dataOut), 32'(dout[1]));
    endtask

    // Called at a negedge: drive, let one posedge pass, then compare at the next negedge.
    task automatic tick(input bit s, input bit b, input bit r);
        bus8.start = s; bus8.serIn = b; bus8.ready = r;
        bus2.start = s; bus2.serIn = b; bus2.ready = r;
        @(posedge clock);
        model_step(s, b, r);
        @(negedge clock);
        check_all();
    endtask

    task automatic send(input int val, input int nbits, input bit r_first);
        for (int i = 0; i < nbits; i++)
            tick(i == 0, bit'((val >> i) & 1), (i == 0) ? r_first : 1'b0);
    endtask

    initial begin
        reset_L = 1'b0;
        bus8.start = 0; bus8.serIn = 0; bus8.ready = 0;
        bus2.start = 0; bus2.serIn = 0; bus2.ready = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        reset_L = 1'b1;

        repeat (3) tick(0, 1, 1);

        // Asynchronous reset between edges in the middle of a frame.
        send(8'h45, 3, 1'b0);
        #2 reset_L = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clock);
        reset_L = 1'b1;
        repeat (2) tick(0, 1, 0);

        // Single frame, held while ready is low.
        send(8'h45, 8, 1'b0);
        check("single_data", 32'(bus8.dataOut), 32'h45);
        check("single_valid", 32'(bus8.valid), 32'd1);
        repeat (5) tick(0, 0, 0);
        tick(0, 0, 1);
        check("accept_valid", 32'(bus8.valid), 32'd0);
        check("accept_data", 32'(bus8.dataOut), 32'h45);

        // Back-to-back frames.
        send(8'h45, 8, 1'b0);
        send(8'hA3, 8, 1'b1);
        check("b2b_data", 32'(bus8.dataOut), 32'hA3);
        tick(0, 0, 1);

        // Restart mid-frame.
        send(8'hFF, 3, 1'b0);
        send(8'h0F, 8, 1'b0);
        check("restart_data", 32'(bus8.dataOut), 32'h0F);
        tick(0, 0, 1);

        // Overrun while holding.
        send(8'h45, 8, 1'b0);
        tick(1, 0, 0);
        check("overrun_pulse", 32'(bus8.overrun), 32'd1);
        tick(0, 1, 0);
        check("overrun_clear", 32'(bus8.overrun), 32'd0);
        for (int i = 2; i < 8; i++) tick(0, bit'((8'h12 >> i) & 1), 0);
        check("overrun_keep", 32'(bus8.dataOut), 32'h45);
        tick(0, 0, 1);
        repeat (3) tick(0, 1, 0);
        check("overrun_idle", 32'(bus8.busy), 32'd0);

        // WIDTH=2: completion one edge after start, then immediate back-to-back.
        tick(0, 0, 1);
        tick(1, 1, 0);
        tick(0, 1, 0);
        check("w2_first", 32'(bus2.dataOut), 32'h3);
        check("w2_valid", 32'(bus2.valid), 32'd1);
        tick(1, 0, 1);
        tick(0, 1, 0);
        check("w2_second", 32'(bus2.dataOut), 32'h2);

        // Random traffic.
        for (int n = 0; n < 400; n++)
            tick(($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
